// File: rtl/fir_pkg.sv
// Shared FIR datapath widths and sample/accumulator types.
// Imported by the 51-tap band-pass FIR and its output conditioning stage.
package fir_pkg;

    localparam int FIR_DATA_W  = 16;
    localparam int FIR_COEFF_W = 16;
    localparam int FIR_ACC_W   = 39;

    typedef logic signed [FIR_DATA_W-1:0] fir_sample_t;
    typedef logic signed [FIR_ACC_W-1:0]  fir_acc_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head (0 when empty).
// Latency: a write is visible on rd_data after the write edge, no bypass.
// Backpressure: writes into a full FIFO are ignored unless a read frees the slot in the same cycle.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rptr];

    // Storage carries no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_decim.sv
// FIR output conditioning: decimate by DECIM, shift right by SHIFT, saturate, buffer in FWFT FIFO.
// Latency: 2 edges from kept input to out_valid; FIR_DECIM_ROUND_EN selects round-half-up.
// Backpressure: none upstream; a kept sample meeting a full FIFO with no pop is dropped (ovf_flag).
module fir_out_decim
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = FIR_ACC_W,
    parameter int OUT_WIDTH  = FIR_DATA_W,
    parameter int SHIFT      = 0,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [IN_WIDTH-1:0]    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    input  logic                          clr_flags
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [IN_WIDTH:0] MAX_V =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MIN_V =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`ifdef FIR_DECIM_ROUND_EN
    localparam logic [IN_WIDTH:0] RND = ((IN_WIDTH+1)'(1) << SHIFT) >> 1;
`endif

    logic [PW-1:0]               phase;
    logic                        keep;
    logic signed [IN_WIDTH:0]    ext;
    logic signed [IN_WIDTH:0]    biased;
    logic signed [IN_WIDTH:0]    shifted;
    logic signed [OUT_WIDTH-1:0] sat_dat;
    logic                        clip;
    logic                        stg_vld;
    logic [OUT_WIDTH-1:0]        stg_dat;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [OUT_WIDTH-1:0]        fifo_rd_data;
    logic                        pop;
    logic                        drop;

    assign keep = in_valid && (phase == '0);

    // One extra bit of headroom so the rounding bias can never wrap.
    always_comb begin
        ext = {in_data[IN_WIDTH-1], in_data};
`ifdef FIR_DECIM_ROUND_EN
        biased = ext + $signed(RND);
`else
        biased = ext;
`endif
        shifted = biased >>> SHIFT;
        clip    = 1'b0;
        sat_dat = shifted[OUT_WIDTH-1:0];
        if (shifted > MAX_V) begin
            sat_dat = MAX_V[OUT_WIDTH-1:0];
            clip    = 1'b1;
        end else if (shifted < MIN_V) begin
            sat_dat = MIN_V[OUT_WIDTH-1:0];
            clip    = 1'b1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data;
    assign pop       = out_valid && out_ready;
    assign drop      = stg_vld && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= '0;
            stg_vld  <= 1'b0;
            stg_dat  <= '0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (in_valid) begin
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
            stg_vld <= keep;
            if (keep) begin
                stg_dat <= sat_dat;
            end
            // A set event in the same cycle as clr_flags wins.
            if (keep && clip) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end
            if (drop) begin
                ovf_flag <= 1'b1;
            end else if (clr_flags) begin
                ovf_flag <= 1'b0;
            end
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (stg_vld),
        .wr_data (stg_dat),
        .full    (fifo_full),
        .rd_en   (out_ready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_fir_out_decim.sv
// Three fir_out_decim configurations on shared stimulus, checked against a queue-based model.
module tb_fir_out_decim;
    localparam int N     = 3;
    localparam int DEPTH = 8;

    logic                clk       = 1'b0;
    logic                rst       = 1'b0;
    logic                in_valid  = 1'b0;
    logic signed [38:0]  in_data   = '0;
    logic                out_ready = 1'b0;
    logic                clr       = 1'b0;

    logic                ov  [N];
    logic signed [15:0]  od  [N];
    logic [3:0]          lvl [N];
    logic                sat [N];
    logic                ovf [N];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // d0: DECIM=1 SHIFT=0, d1: DECIM=4 SHIFT=0, d2: DECIM=1 SHIFT=2
    fir_out_decim #(.IN_WIDTH(39), .OUT_WIDTH(16), .SHIFT(0), .DECIM(1), .FIFO_DEPTH(DEPTH)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .fifo_level(lvl[0]),
        .sat_flag(sat[0]), .ovf_flag(ovf[0]), .clr_flags(clr));
    fir_out_decim #(.IN_WIDTH(39), .OUT_WIDTH(16), .SHIFT(0), .DECIM(4), .FIFO_DEPTH(DEPTH)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .fifo_level(lvl[1]),
        .sat_flag(sat[1]), .ovf_flag(ovf[1]), .clr_flags(clr));
    fir_out_decim #(.IN_WIDTH(39), .OUT_WIDTH(16), .SHIFT(2), .DECIM(1), .FIFO_DEPTH(DEPTH)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .fifo_level(lvl[2]),
        .sat_flag(sat[2]), .ovf_flag(ovf[2]), .clr_flags(clr));

    function automatic int dec_of(int k);
        return (k == 1) ? 4 : 1;
    endfunction

    function automatic int sh_of(int k);
        return (k == 2) ? 2 : 0;
    endfunction

    // x / 2^sh rounded toward minus infinity, optionally after a half-LSB bias.
    function automatic longint scale(longint x, int sh);
        longint d;
        longint y;
        d = longint'(1) << sh;
        y = x;
`ifdef FIR_DECIM_ROUND_EN
        if (sh > 0) y = y + d / 2;
`endif
        if (y >= 0) return y / d;
        return -((-y + d - 1) / d);
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: kept samples queue up one edge late; FIFO is a bounded queue.
    int     mq     [N][$];
    bit     mstg_v [N];
    longint mstg_d [N];
    int     mvcnt  [N];
    bit     msat   [N];
    bit     movf   [N];

    always @(posedge clk or negedge rst) begin
        bit     pop;
        bit     sev;
        bit     oev;
        longint v;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                mq[k].delete();
                mstg_v[k] = 1'b0;
                mstg_d[k] = 0;
                mvcnt[k]  = 0;
                msat[k]   = 1'b0;
                movf[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                pop = (mq[k].size() > 0) && out_ready;
                if (pop) void'(mq[k].pop_front());
                oev = 1'b0;
                if (mstg_v[k]) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back(int'(mstg_d[k]));
                    else oev = 1'b1;
                end
                sev = 1'b0;
                mstg_v[k] = 1'b0;
                if (in_valid && (mvcnt[k] % dec_of(k) == 0)) begin
                    v = scale(longint'(in_data), sh_of(k));
                    if (v > 32767) begin v = 32767; sev = 1'b1; end
                    if (v < -32768) begin v = -32768; sev = 1'b1; end
                    mstg_v[k] = 1'b1;
                    mstg_d[k] = v;
                end
                if (in_valid) mvcnt[k]++;
                msat[k] = sev ? 1'b1 : (clr ? 1'b0 : msat[k]);
                movf[k] = oev ? 1'b1 : (clr ? 1'b0 : movf[k]);
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            chk($sformatf("d%0d out_valid", k), ov[k], mq[k].size() > 0);
            chk($sformatf("d%0d fifo_level", k), lvl[k], mq[k].size());
            chk($sformatf("d%0d sat_flag", k), sat[k], msat[k]);
            chk($sformatf("d%0d ovf_flag", k), ovf[k], movf[k]);
            if (mq[k].size() > 0) chk($sformatf("d%0d out_data", k), od[k], mq[k][0]);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst d%0d out_valid", k), ov[k], 0);
            chk($sformatf("rst d%0d out_data", k), od[k], 0);
            chk($sformatf("rst d%0d fifo_level", k), lvl[k], 0);
            chk($sformatf("rst d%0d flags", k), {sat[k], ovf[k]}, 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive(input bit vld, input longint v);
        in_valid = vld;
        in_data  = 39'(v);
    endtask

    function automatic longint rnd_data();
        case ($urandom_range(3))
            0:       return longint'($urandom_range(4000)) - 2000;
            1:       return longint'($urandom_range(100000)) - 50000;
            2:       return longint'($urandom_range(300000)) - 150000;
            default: return longint'(39'({$urandom, $urandom})) - (longint'(1) << 38);
        endcase
    endfunction

    initial begin
        int     got [$];
        int     maxl;
        longint r1;
        longint r2;

        // Pass-through with 2-edge latency
        do_reset();
        out_ready = 1'b1;
        drive(1, 1000);
        @(negedge clk);
        chk("pass not yet valid", ov[0], 0);
        drive(1, -1000);
        @(negedge clk);
        chk("pass first valid", ov[0], 1);
        chk("pass first data", od[0], 1000);
        drive(0, 0);
        @(negedge clk);
        chk("pass second data", od[0], -1000);
        @(negedge clk);
        chk("pass drained", ov[0], 0);

        // Saturation and sticky flag clear
        do_reset();
        out_ready = 1'b1;
        drive(1, 40000);
        @(negedge clk);
        chk("sat flag set", sat[0], 1);
        drive(1, -40000);
        @(negedge clk);
        drive(0, 0);
        chk("sat high clip", od[0], 32767);
        @(negedge clk);
        chk("sat low clip", od[0], -32768);
        chk("sat flag held", sat[0], 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("sat flag cleared", sat[0], 0);
        chk("sat shift2 no clip", sat[2], 0);

        // Rounding vs truncation at SHIFT=2
`ifdef FIR_DECIM_ROUND_EN
        r1 = 2;  r2 = -1;
`else
        r1 = 1;  r2 = -2;
`endif
        do_reset();
        out_ready = 1'b1;
        drive(1, 6);
        @(negedge clk);
        drive(1, -6);
        @(negedge clk);
        drive(0, 0);
        chk("round +6", od[2], r1);
        @(negedge clk);
        chk("round -6", od[2], r2);

        // Decimation by 4 on a ramp
        do_reset();
        out_ready = 1'b1;
        got.delete();
        maxl = 0;
        for (int i = 0; i < 20; i++) begin
            if (ov[1]) got.push_back(int'(od[1]));
            if (int'(lvl[1]) > maxl) maxl = int'(lvl[1]);
            drive(i < 16, i);
            @(negedge clk);
        end
        chk("decim count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("decim out %0d", i), got[i], 4 * i);
        chk("decim max level", maxl, 1);

        // Overflow then simultaneous read/write drain
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive(1, i);
            @(negedge clk);
        end
        drive(0, 0);
        @(negedge clk);
        chk("ovf level", lvl[0], 8);
        chk("ovf flag", ovf[0], 1);
        chk("ovf head", od[0], 1);
        got.delete();
        for (int j = 0; j < 12; j++) begin
            out_ready = 1'b1;
            if (ov[0]) got.push_back(int'(od[0]));
            drive(1, 11 + j);
            @(negedge clk);
        end
        drive(0, 0);
        chk("drain count", got.size(), 12);
        for (int j = 0; j < 10 && j < got.size(); j++)
            chk($sformatf("drain order %0d", j), got[j], (j < 8) ? j + 1 : j + 3);

        // Asynchronous reset mid-stream, phase restarts
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1, i);
            @(negedge clk);
        end
        drive(0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mid level before rst", lvl[0], 5);
        #2 rst = 1'b0;
        #1;
        chk("mid rst out_valid", ov[0], 0);
        chk("mid rst level", lvl[0], 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 10; i++) begin
            if (ov[1]) got.push_back(int'(od[1]));
            drive(i < 5, 100 + i);
            @(negedge clk);
        end
        chk("mid first d1 count", got.size(), 2);
        if (got.size() > 0) chk("mid first d1 sample", got[0], 100);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(9) < 8, rnd_data());
            out_ready = (c % 500 < 250) ? ($urandom_range(9) < 5) : ($urandom_range(9) < 9);
            clr = ($urandom_range(49) == 0);
            @(negedge clk);
        end
        drive(0, 0);
        clr = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
